// File: rtl/shift_reg_serial_tx_if.sv
// Word handshake plus mode/serial control lines toward a 4-bit bidirectional shift register.
interface shift_reg_serial_tx_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_dir;
    logic             s0;
    logic             s1;
    logic             ds0;
    logic             ds3;
    logic             busy;
    logic             done;

    modport master (
        output in_valid, in_data, in_dir,
        input  in_ready, s0, s1, ds0, ds3, busy, done
    );

    modport slave (
        input  in_valid, in_data, in_dir,
        output in_ready, s0, s1, ds0, ds3, busy, done
    );
endinterface

// File: rtl/shift_reg_serial_tx.sv
// Serialises one accepted word into a downstream bidirectional shift register.
// Latency: done one cycle after WIDTH shift cycles; in_ready low from handshake until IDLE returns (WIDTH+2 cycles per word).
module shift_reg_serial_tx #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 mr,
    shift_reg_serial_tx_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             dir_q, dir_d;

    logic s0_q, s1_q, ds0_q, ds3_q, busy_q, done_q;
    logic s0_d, s1_d, ds0_d, ds3_d, busy_d, done_d;
    logic bit_msb, bit_lsb;

    assign bus.in_ready = (state_q == IDLE);
    assign bus.s0       = s0_q;
    assign bus.s1       = s1_q;
    assign bus.ds0      = ds0_q;
    assign bus.ds3      = ds3_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

    always_ff @(posedge clk) begin
        if (!mr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            dir_q   <= 1'b0;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            ds0_q   <= 1'b0;
            ds3_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            dir_q   <= dir_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            ds0_q   <= ds0_d;
            ds3_q   <= ds3_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    word_d  = bus.in_data;
                    dir_d   = bus.in_dir;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from next-state values so the bit for counter k is on the pins right after edge k.
    always_comb begin
        bit_msb = 1'b0;
        bit_lsb = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_d == CNT_W'(i)) begin
                bit_msb = word_d[WIDTH-1-i];
                bit_lsb = word_d[i];
            end
        end

        s0_d   = 1'b0;
        s1_d   = 1'b0;
        ds0_d  = 1'b0;
        ds3_d  = 1'b0;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        if (state_d == SHIFT) begin
            if (dir_d) begin
                s0_d  = 1'b1;
                ds3_d = bit_lsb;
            end else begin
                s1_d  = 1'b1;
                ds0_d = bit_msb;
            end
        end
    end
endmodule

// File: tb/tb_shift_reg_serial_tx.sv
// Bench for shift_reg_serial_tx with a behavioural downstream register and a word scoreboard.
module tb_shift_reg_serial_tx;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic mr  = 1'b0;
    always #5 clk = ~clk;

    shift_reg_serial_tx_if #(.WIDTH(WIDTH)) bus ();

    shift_reg_serial_tx #(.WIDTH(WIDTH), .CNT_W(3)) dut (
        .clk (clk),
        .mr  (mr),
        .bus (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    logic [WIDTH-1:0] down_q = '0;
    logic [WIDTH-1:0] sb_q[$];
    int hs_cnt   = 0;
    int done_cnt = 0;
    int aborted  = 0;
    int hs_cyc   = 0;
    int cyc      = 0;

    // Downstream register model plus handshake capture, all on pre-edge values.
    always @(posedge clk) begin
        cyc++;
        case ({bus.s0, bus.s1})
            2'b01:   down_q <= {down_q[WIDTH-2:0], bus.ds0};
            2'b10:   down_q <= {bus.ds3, down_q[WIDTH-1:1]};
            default: down_q <= down_q;
        endcase
        if (!mr) begin
            aborted += sb_q.size();
            sb_q.delete();
        end else if (bus.in_valid && bus.in_ready) begin
            sb_q.push_back(bus.in_data);
            hs_cnt++;
            hs_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        if (cyc > 0)
            chk("mode11", 32'({bus.s0, bus.s1} == 2'b11), 32'd0);
        if (bus.done) begin
            done_cnt++;
            if (sb_q.size() == 0)
                chk("done_unexpected", 32'd1, 32'd0);
            else
                chk("sb_word", 32'(down_q), 32'(sb_q.pop_front()));
        end
    end

    task automatic wait_hs(input int n0);
        int g;
        g = 0;
        while (hs_cnt == n0 && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("hs_timeout", 32'(g < 50), 32'd1);
    endtask

    task automatic xfer(input logic [WIDTH-1:0] w, input logic d);
        int n0;
        logic [WIDTH-1:0] sh;
        n0 = hs_cnt;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        bus.in_dir   = d;
        wait_hs(n0);
        bus.in_valid = 1'b0;
        bus.in_data  = ~w;
        bus.in_dir   = ~d;
        for (int k = 0; k < WIDTH; k++) begin
            @(negedge clk);
            chk("shift_mode", 32'({bus.s0, bus.s1}), d ? 32'd2 : 32'd1);
            if (!d) begin
                sh = w << k;
                chk("ds0_bit", 32'(bus.ds0), 32'(sh[WIDTH-1]));
                chk("ds3_idle", 32'(bus.ds3), 32'd0);
            end else begin
                sh = w >> k;
                chk("ds3_bit", 32'(bus.ds3), 32'(sh[0]));
                chk("ds0_idle", 32'(bus.ds0), 32'd0);
            end
            chk("busy_shift", 32'(bus.busy), 32'd1);
            chk("rdy_shift", 32'(bus.in_ready), 32'd0);
            chk("done_early", 32'(bus.done), 32'd0);
        end
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_mode", 32'({bus.s0, bus.s1, bus.ds0, bus.ds3}), 32'd0);
        chk("done_busy", 32'(bus.busy), 32'd1);
        chk("done_word", 32'(down_q), 32'(w));
        @(negedge clk);
        chk("done_clear", 32'(bus.done), 32'd0);
        chk("rdy_back", 32'(bus.in_ready), 32'd1);
        chk("busy_clear", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, c1, c2, d0;
        bus.in_valid = 1'b1;
        bus.in_data  = '0;
        bus.in_dir   = 1'b0;
        mr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s0", 32'(bus.s0), 32'd0);
        chk("rst_s1", 32'(bus.s1), 32'd0);
        chk("rst_ds0", 32'(bus.ds0), 32'd0);
        chk("rst_ds3", 32'(bus.ds3), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
        mr = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", 32'(bus.in_ready), 32'd1);

        xfer(4'b1011, 1'b0);
        xfer(4'b1011, 1'b1);

        // Back-to-back with in_valid held; data changes mid-shift must not leak into the first word.
        @(posedge clk);
        #1;
        n0 = hs_cnt;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'hA;
        bus.in_dir   = 1'b0;
        wait_hs(n0);
        c1 = hs_cyc;
        bus.in_data = 4'h5;
        wait_hs(n0 + 1);
        c2 = hs_cyc;
        bus.in_valid = 1'b0;
        chk("b2b_gap", 32'(c2 - c1), 32'd6);
        repeat (8) @(posedge clk);
        chk("b2b_dones", 32'(done_cnt), 32'(hs_cnt));

        // Reset in the middle of a transfer.
        #1;
        n0 = hs_cnt;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'hC;
        bus.in_dir   = 1'b0;
        wait_hs(n0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        d0 = done_cnt;
        mr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_mode", 32'({bus.s0, bus.s1}), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
        mr = 1'b1;
        @(negedge clk);
        chk("midrst_rdy", 32'(bus.in_ready), 32'd1);
        repeat (6) @(posedge clk);
        chk("midrst_no_done", 32'(done_cnt), 32'(d0));
        xfer(4'h3, 1'b0);

        for (int i = 0; i < 200; i++)
            xfer(WIDTH'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

        repeat (3) @(posedge clk);
        chk("done_vs_hs", 32'(done_cnt), 32'(hs_cnt - aborted));
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
